sc_stream_sequencer: RTL and testbench

Sequencer and owner of the shared stochastic-computing core. It holds the 8-bit LFSR state and the one-cycle feedback flop that the combinational core uses. On a start handshake it seeds the LFSR and latches the binary operand. It then clocks the core for a programmed number of bitstream cycles, counts the ones in the core's output stream, and returns the count with a one-cycle done pulse. It sits between the host and exactly one combinational core instance.

---
 rtl/sc_stream_sequencer.sv | 133 +++++++++++++
 tb/tb_sc_stream_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_sequencer.sv
// sc_stream_sequencer: owns the LFSR and feedback flop of one combinational
// stochastic-computing core, runs it for a programmed number of cycles and
// returns the count of ones in the core output stream.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; core_s/core_b hold their last values
//   RUN   | core clocked once per cycle, ones accumulated
//   DONE  | one-cycle done pulse, result already holds the final count
module sc_stream_sequencer #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seed,
  input  logic [7:0]       operand_b,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] result,
  output logic [7:0]       core_s,
  output logic [7:0]       core_b,
  output logic             core_x1,
  input  logic             core_x0,
  input  logic             core_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       b_q, b_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cyc_q, cyc_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic             x1_q, x1_d;
  logic [LEN_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    b_d      = b_q;
    len_d    = len_q;
    cyc_d    = cyc_q;
    acc_d    = acc_q;
    x1_d     = x1_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        // abort in IDLE blocks a simultaneous start
        if (start && !abort) begin
          lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
          b_d    = operand_b;
          len_d  = len;
          cyc_d  = '0;
          acc_d  = '0;
          x1_d   = 1'b0;
          if (len == '0) begin
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d  = acc_q + {{(LEN_W-1){1'b0}}, core_out};
        x1_d   = core_x0;
        lfsr_d = {lfsr_q[7] ^ lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0], lfsr_q[7:1]};
        cyc_d  = cyc_q + ONE;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cyc_q == len_q - ONE) begin
          // result is loaded on the way into DONE so it is valid with done
          state_d  = ST_DONE;
          result_d = acc_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= 8'h01;
      b_q      <= 8'h00;
      len_q    <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      x1_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      b_q      <= b_d;
      len_q    <= len_d;
      cyc_q    <= cyc_d;
      acc_q    <= acc_d;
      x1_q     <= x1_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign core_s  = lfsr_q;
  assign core_b  = b_q;
  assign core_x1 = x1_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Directed and randomized checks of sc_stream_sequencer with a stub core
// (core_x0 = core_s < core_b, core_out = core_x0).
module tb_sc_stream_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic [7:0] operand_b;
  logic [9:0] len;
  logic       busy;
  logic       done;
  logic [9:0] result;
  logic [7:0] core_s;
  logic [7:0] core_b;
  logic       core_x1;
  logic       core_x0;
  logic       core_out;

  int checks;
  int passed;
  int fails;

  sc_stream_sequencer #(.LEN_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .operand_b (operand_b),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .core_s    (core_s),
    .core_b    (core_b),
    .core_x1   (core_x1),
    .core_x0   (core_x0),
    .core_out  (core_out)
  );

  assign core_x0  = (core_s < core_b);
  assign core_out = core_x0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_lfsr(input logic [7:0] s);
    return {s[7] ^ s[2] ^ s[1] ^ s[0], s[7:1]};
  endfunction

  function automatic logic [9:0] model_result(input logic [7:0] sd, input logic [7:0] ob,
                                              input logic [9:0] ln);
    logic [7:0] s;
    logic [9:0] acc;
    s   = (sd == 8'h00) ? 8'h01 : sd;
    acc = '0;
    for (int i = 0; i < int'(ln); i++) begin
      if (s < ob) acc = acc + 10'd1;
      s = next_lfsr(s);
    end
    return acc;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
  task automatic run_chk(input string tag, input logic [7:0] sd, input logic [7:0] ob,
                         input logic [9:0] ln);
    int n;
    logic [9:0] exp;
    exp = model_result(sd, ob, ln);
    seed = sd; operand_b = ob; len = ln; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < int'(ln) + 5) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_lat"}, n, int'(ln) + 1);
    chk({tag, "_result"}, {22'd0, result}, {22'd0, exp});
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  logic [7:0] s_seq [7];
  logic       x1_seq [4];
  logic [9:0] prior;
  int         n;

  initial begin
    checks = 0; passed = 0; fails = 0;
    s_seq  = '{8'h01, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC};
    x1_seq = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    seed = 8'h00; operand_b = 8'h00; len = 10'd0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {22'd0, result}, 32'd0);
    chk("rst_core_s", {24'd0, core_s}, 32'h01);
    chk("rst_core_b", {24'd0, core_b}, 32'h00);
    chk("rst_core_x1", {31'd0, core_x1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LFSR sequence from seed 01 over 7 RUN cycles
    seed = 8'h01; operand_b = 8'h00; len = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("lfsr_s%0d", k), {24'd0, core_s}, {24'd0, s_seq[k]});
      chk($sformatf("lfsr_busy%0d", k), {30'd0, busy, done}, 32'd2);
      @(negedge clk);
    end
    chk("lfsr_done", {31'd0, done}, 32'd1);
    chk("lfsr_next", {24'd0, core_s}, 32'h7E);
    chk("lfsr_result", {22'd0, result}, 32'd0);
    @(negedge clk);
    chk("lfsr_hold_idle", {24'd0, core_s}, 32'h7E);

    // operand 90, len 4: feedback bit and count
    seed = 8'h01; operand_b = 8'h90; len = 10'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("x1_%0d", k), {31'd0, core_x1}, {31'd0, x1_seq[k]});
      chk($sformatf("x1_nodone%0d", k), {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("b90_done", {31'd0, done}, 32'd1);
    chk("b90_result", {22'd0, result}, 32'd2);
    chk("b90_core_b", {24'd0, core_b}, 32'h90);
    @(negedge clk);

    // zero seed substitutes 01
    seed = 8'h00; operand_b = 8'h90; len = 10'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seed0_s", {24'd0, core_s}, 32'h01);
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    chk("seed0_done", {31'd0, done}, 32'd1);
    chk("seed0_result", {22'd0, result}, 32'd2);
    @(negedge clk);

    // len 0: done one cycle after accept, result 0
    run_chk("len0", 8'h55, 8'hFF, 10'd0);

    // start pulsed mid-run is ignored
    seed = 8'h01; operand_b = 8'h90; len = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; seed = 8'h3C; len = 10'd2;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midstart_lat", n, 11);
    chk("midstart_result", {22'd0, result}, {22'd0, model_result(8'h01, 8'h90, 10'd10)});
    @(negedge clk);
    chk("midstart_no_rerun", {31'd0, busy}, 32'd0);
    prior = result;

    // abort at RUN cycle 3 of len 10
    seed = 8'hA5; operand_b = 8'hF0; len = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {30'd0, busy, done}, 32'd0);
    chk("abort_result", {22'd0, result}, {22'd0, prior});
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);

    // start with abort in IDLE is refused
    start = 1'b1; abort = 1'b1; len = 10'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_wins", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-run
    seed = 8'h77; operand_b = 8'h80; len = 10'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", {22'd0, result}, 32'd0);
    chk("arst_core_s", {24'd0, core_s}, 32'h01);
    chk("arst_core_b", {24'd0, core_b}, 32'h00);
    chk("arst_core_x1", {31'd0, core_x1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_chk("post_rst", 8'h77, 8'h80, 10'd20);

    // long run at maximum length
    run_chk("maxlen", 8'hC3, 8'h7B, 10'd1023);

    // randomized runs against the model
    for (int r = 0; r < 200; r++) begin
      run_chk($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 10'($urandom_range(1, 400)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
